frequency_divider_by5: RTL and testbench



---
 rtl/freq_div_pkg.sv | 11 +
 rtl/freq_div_counter.sv | 36 +++
 rtl/frequency_divider_by5.sv | 62 ++++++
 tb/tb_frequency_divider_by5.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the odd/even 50%-duty clock divider.
package freq_div_pkg;

  localparam int DEFAULT_DIVISOR = 5;

  // Length of the rising-edge HIGH phase in whole source-clock cycles.
  function automatic int freq_div_half(input int d);
    return d / 2;
  endfunction

endpackage

// File: rtl/freq_div_counter.sv
// Modulo-DIVISOR up-counter with asynchronous reset to DIVISOR-1, so the first
// rising edge after reset wraps it to 0.
module freq_div_counter
  import freq_div_pkg::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR,
  parameter int CNT_W   = $clog2(DIVISOR)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] cnt_next_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= CNT_MAX;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/frequency_divider_by5.sv
// Divides CLK_IN by DIVISOR with 50% duty; odd ratios add a falling-edge copy
// of the rising-edge phase so the HIGH time gains the missing half cycle.
module frequency_divider_by5
  import freq_div_pkg::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR,
  parameter int CNT_W   = $clog2(DIVISOR)
) (
  input  logic CLK_IN,
  input  logic RST,
  output logic CLK_OUT
);

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("frequency_divider_by5: DIVISOR must be >= 2");
  end

  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(freq_div_half(DIVISOR));

  logic [CNT_W-1:0] cnt_next;
  logic             pos_q;
  logic             pos_d;

  freq_div_counter #(
    .DIVISOR (DIVISOR),
    .CNT_W   (CNT_W)
  ) u_counter (
    .clk_i      (CLK_IN),
    .rst_i      (RST),
    .cnt_next_o (cnt_next)
  );

  always_comb begin
    pos_d = (cnt_next < HALF_C);
  end

  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      pos_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
    end
  end

  if (DIVISOR[0]) begin : g_odd
    logic neg_q;

    // Both terms overlap at every transition, so the OR cannot glitch.
    always_ff @(negedge CLK_IN or posedge RST) begin
      if (RST) begin
        neg_q <= 1'b0;
      end else begin
        neg_q <= pos_q;
      end
    end

    assign CLK_OUT = pos_q | neg_q;
  end else begin : g_even
    assign CLK_OUT = pos_q;
  end

endmodule

// File: tb/tb_frequency_divider_by5.sv
// Directed bench for frequency_divider_by5: default divide-by-5 plus a sweep of
// DIVISOR=2,3,4,6,7, all sharing one source clock and reset.
module tb_frequency_divider_by5;

  localparam int NDUT = 6;
  localparam int DIVS [NDUT] = '{5, 2, 3, 4, 6, 7};

  logic            clk_in;
  logic            rst;
  wire  [NDUT-1:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  logic  [NDUT-1:0] prev_out;
  longint           last_rise     [NDUT];
  longint           last_fall     [NDUT];
  bit               first_pending [NDUT];
  int               n_periods     [NDUT];
  longint           exp_first;
  longint           t_drop;

  int     glitch_cnt = 0;
  longint last_chg   = 0;
  bit     have_chg   = 1'b0;

  frequency_divider_by5 dut (
    .CLK_IN  (clk_in),
    .RST     (rst),
    .CLK_OUT (outs[0])
  );

  for (genvar gi = 1; gi < NDUT; gi++) begin : g_sweep
    frequency_divider_by5 #(
      .DIVISOR (DIVS[gi])
    ) u_dut (
      .CLK_IN  (clk_in),
      .RST     (rst),
      .CLK_OUT (outs[gi])
    );
  end

  initial begin
    clk_in = 1'b0;
    forever #2 clk_in = ~clk_in;
  end

  // Any two changes of the divide-by-5 output closer than 2 time units outside reset.
  always @(outs[0]) begin
    if (!rst && have_chg && (($time - last_chg) < 2)) begin
      glitch_cnt++;
    end
    last_chg = $time;
    have_chg = 1'b1;
  end

  task automatic check_val(input string tag, input longint observed, input longint expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic forget_edges();
    for (int k = 0; k < NDUT; k++) begin
      last_rise[k] = -1;
      last_fall[k] = -1;
    end
  endtask

  task automatic arm_first_rise(input longint t_first);
    exp_first = t_first;
    for (int k = 0; k < NDUT; k++) begin
      first_pending[k] = 1'b1;
    end
  endtask

  // Outputs only move on even times (clock edges); sampling on odd times pins
  // every edge to the sample time minus 1.
  task automatic run_samples(input int n);
    longint e;
    for (int s = 0; s < n; s++) begin
      #2;
      e = $time - 1;
      for (int k = 0; k < NDUT; k++) begin
        if (outs[k] !== prev_out[k]) begin
          if (!rst) begin
            if (outs[k]) begin
              if (first_pending[k]) begin
                check_val($sformatf("first_rise_d%0d", DIVS[k]), e, exp_first);
                first_pending[k] = 1'b0;
              end else if (last_rise[k] >= 0) begin
                check_val($sformatf("period_d%0d", DIVS[k]), e - last_rise[k], DIVS[k] * 4);
                n_periods[k]++;
              end
              if (last_fall[k] >= 0) begin
                check_val($sformatf("low_d%0d", DIVS[k]), e - last_fall[k], DIVS[k] * 2);
              end
              last_rise[k] = e;
            end else begin
              if (last_rise[k] >= 0) begin
                check_val($sformatf("high_d%0d", DIVS[k]), e - last_rise[k], DIVS[k] * 2);
              end
              last_fall[k] = e;
            end
          end
          prev_out[k] = outs[k];
        end
      end
    end
  endtask

  task automatic assert_reset_and_time_drop();
    rst = 1'b1;
    fork
      begin
        wait (outs[0] == 1'b0);
      end
      begin
        #1;
      end
    join_any
    disable fork;
    t_drop = $time;
  endtask

  localparam int CNT_SEQ [6] = '{0, 1, 2, 3, 4, 0};
  localparam int OUT_SEQ [6] = '{1, 1, 1, 0, 0, 1};

  initial begin
    rst = 1'b1;
    prev_out = '0;
    forget_edges();
    for (int k = 0; k < NDUT; k++) begin
      first_pending[k] = 1'b0;
      n_periods[k]     = 0;
    end

    // Reset state; release falls between clock edges, just ahead of the t=2 rise.
    #1;
    check_val("reset_clk_out", outs[0], 0);
    check_val("reset_cnt", longint'(dut.u_counter.cnt_q), 4);
    check_val("reset_pos_q", dut.pos_q, 0);
    check_val("reset_neg_q", dut.g_odd.neg_q, 0);
    check_val("reset_all_outs", longint'(outs), 0);
    rst = 1'b0;
    arm_first_rise(2);

    // Counter wrap 4,0,1,2,3,4,0 and CLK_OUT rising only with cnt==0.
    for (int i = 0; i < 6; i++) begin
      run_samples((i == 0) ? 1 : 2);
      check_val($sformatf("cnt_seq%0d", i), longint'(dut.u_counter.cnt_q), CNT_SEQ[i]);
      check_val($sformatf("out_seq%0d", i), outs[0], OUT_SEQ[i]);
    end

    // Mid-run reset during a HIGH phase, asserted away from any clock edge.
    run_samples(40);
    check_val("pre_reset_high", outs[0], 1);
    assert_reset_and_time_drop();
    check_val("async_drop_t", t_drop, 103);
    check_val("async_drop_val", outs[0], 0);
    forget_edges();
    for (int i = 0; i < 9; i++) begin
      run_samples(1);
      check_val($sformatf("hold_low%0d", i), outs[0], 0);
    end
    run_samples(1);
    check_val("hold_cnt", longint'(dut.u_counter.cnt_q), 4);
    rst = 1'b0;
    arm_first_rise(126);
    run_samples(1);
    check_val("post_release_low", outs[0], 0);
    run_samples(165);

    // Reset in the trailing half-cycle where only neg_q holds CLK_OUT high.
    check_val("tail_out", outs[0], 1);
    check_val("tail_pos_q", dut.pos_q, 0);
    check_val("tail_neg_q", dut.g_odd.neg_q, 1);
    assert_reset_and_time_drop();
    check_val("tail_drop_t", t_drop, 455);
    forget_edges();
    run_samples(2);
    // Released one unit before a falling edge: neg_q must stay clear.
    rst = 1'b0;
    arm_first_rise(462);
    run_samples(1);
    check_val("fall_release_out", outs[0], 0);
    check_val("fall_release_neg_q", dut.g_odd.neg_q, 0);
    run_samples(40);

    check_val("glitches_d5", glitch_cnt, 0);
    for (int k = 0; k < NDUT; k++) begin
      check_val($sformatf("first_seen_d%0d", DIVS[k]), first_pending[k], 0);
      check_val($sformatf("enough_periods_d%0d", DIVS[k]), (n_periods[k] >= 10) ? 1 : 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
